// File: rtl/div_pkg.sv
// Shared definitions for the divider arbiter and the external divider.
package div_pkg;
  localparam int DIV_WIDTH = 9;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // States in which the divider buses carry the latched operands.
  function automatic logic drives_div(input logic [2:0] st);
    return (st == S_START) || (st == S_WAIT_LOW) || (st == S_WAIT_HIGH);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; 'last' remembers who was served most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic last;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)      last <= 1'b1;
    else if (upd) last <= upd_id;
  end

  assign gnt_vld = |req;
  assign gnt_id  = (&req) ? ~last : req[1];
endmodule

// File: rtl/div_arbiter.sv
// Shares one external handshake divider between two requesters.
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dz_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  input  logic             div_ready
);
  logic [2:0]       state;
  logic             owner;
  logic [WIDTH-1:0] la, lb;
  logic             gnt_vld, gnt_id;
  logic [WIDTH-1:0] op_a, op_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .upd     (state == S_DONE),
    .upd_id  (owner),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign op_a = gnt_id ? a1 : a0;
  assign op_b = gnt_id ? b1 : b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      la     <= '0;
      lb     <= '0;
      q_out  <= '0;
      r_out  <= '0;
      dz_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          owner <= gnt_id;
          la    <= op_a;
          lb    <= op_b;
          // Zero divisor never reaches the divider; result is formed here.
          if (op_b == '0) begin
            q_out  <= '1;
            r_out  <= op_a;
            dz_err <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_START;
          end
        end
        S_START:     state <= S_WAIT_LOW;
        S_WAIT_LOW:  if (!div_ready) state <= S_WAIT_HIGH;
        S_WAIT_HIGH: if (div_ready) begin
          q_out  <= div_q;
          r_out  <= div_r;
          dz_err <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:      state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign done0     = (state == S_DONE) && !owner;
  assign done1     = (state == S_DONE) &&  owner;
  assign div_start = (state == S_START);
  assign div_a     = drives_div(state) ? la : '0;
  assign div_b     = drives_div(state) ? lb : '0;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, directed vectors, random traffic vs model.
module tb_div_arbiter;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, dz_err, div_start;
  logic [W-1:0] q_out, r_out, div_a, div_b;
  logic [W-1:0] dv_q = '0, dv_r = '0, dv_la = '0, dv_lb = '0;
  logic         dv_rdy = 1'b1;
  int           dv_cnt = 0;
  int           busy_cfg = -1;
  int           nstart = 0;
  int           n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .q_out(q_out), .r_out(r_out), .dz_err(dz_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(dv_q), .div_r(dv_r), .div_ready(dv_rdy)
  );

  // External divider: ready drops on start, rises after a busy period with the result.
  always @(posedge clk) begin
    if (rst) begin
      dv_rdy <= 1'b1;
      dv_cnt <= 0;
    end else if (div_start) begin
      dv_rdy <= 1'b0;
      dv_la  <= div_a;
      dv_lb  <= div_b;
      dv_cnt <= (busy_cfg < 0) ? int'($urandom_range(0, 4)) : busy_cfg;
    end else if (!dv_rdy) begin
      if (dv_cnt == 0) begin
        dv_rdy <= 1'b1;
        dv_q   <= (dv_lb == 0) ? '1 : dv_la / dv_lb;
        dv_r   <= (dv_lb == 0) ? dv_la : dv_la % dv_lb;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (div_start) nstart++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic r, input int a, input int b);
    logic [31:0] av, bv;
    av = a; bv = b;
    if (i == 0) begin req0 = r; a0 = av[W-1:0]; b0 = bv[W-1:0]; end
    else        begin req1 = r; a1 = av[W-1:0]; b1 = bv[W-1:0]; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_done0"}, int'(done0), 0);
    chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_start"}, int'(div_start), 0);
    chk({tag, "_diva"},  int'(div_a), 0);
    chk({tag, "_divb"},  int'(div_b), 0);
    chk({tag, "_q"},     int'(q_out), 0);
    chk({tag, "_r"},     int'(r_out), 0);
    chk({tag, "_dz"},    int'(dz_err), 0);
  endtask

  // Waits (bounded) for a done pulse; own = -1 on timeout, lat = edges waited.
  task automatic wait_done(output int own, output int lat);
    own = -1; lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (done0 || done1) begin
        own = done1 ? 1 : 0;
        return;
      end
    end
  endtask

  task automatic wait_start(output int ok);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (div_start) begin ok = 1; return; end
    end
  endtask

  task automatic chk_res(input string tag, input int own, input int eown,
                         input int q, input int r, input int dz);
    chk({tag, "_owner"}, own, eown);
    chk({tag, "_q"}, int'(q_out), q);
    chk({tag, "_r"}, int'(r_out), r);
    chk({tag, "_dz"}, int'(dz_err), dz);
  endtask

  typedef struct { int sel; int a; int b; int q; int r; int dz; } vec_t;
  vec_t vt[8];

  initial begin
    int own, lat, ok, s0;

    vt[0] = '{0, 100,   7,  14,  2, 0};
    vt[1] = '{1,   5,   0, 511,  5, 1};
    vt[2] = '{0,  81,   9,   9,  0, 0};
    vt[3] = '{1, 255,  16,  15, 15, 0};
    vt[4] = '{0,   0,   3,   0,  0, 0};
    vt[5] = '{1, 511,   1, 511,  0, 0};
    vt[6] = '{0,   7,   0, 511,  7, 1};
    vt[7] = '{1,   3, 200,   0,  3, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // Single-requester vectors, including divide-by-zero latency and pulse width.
    foreach (vt[i]) begin
      s0 = nstart;
      drive(vt[i].sel, 1'b1, vt[i].a, vt[i].b);
      wait_done(own, lat);
      chk_res($sformatf("vec%0d", i), own, vt[i].sel, vt[i].q, vt[i].r, vt[i].dz);
      chk($sformatf("vec%0d_starts", i), nstart - s0, vt[i].dz ? 0 : 1);
      if (vt[i].dz != 0) chk($sformatf("vec%0d_dzlat", i), lat, 1);
      drive(vt[i].sel, 1'b0, vt[i].a, vt[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), int'(done0 | done1), 0);
      chk($sformatf("vec%0d_hold", i), int'(q_out), vt[i].q);
    end

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    drive(0, 1'b1, 50, 5);
    drive(1, 1'b1, 9, 4);
    wait_done(own, lat);
    chk_res("both_first", own, 0, 10, 0, 0);
    drive(0, 1'b0, 50, 5);
    wait_done(own, lat);
    chk_res("both_second", own, 1, 2, 1, 0);
    drive(1, 1'b0, 9, 4);
    @(negedge clk);

    // Continuous req0 with req1 joining: grants alternate.
    drive(0, 1'b1, 20, 3);
    wait_start(ok);
    chk("alt_start_seen", ok, 1);
    drive(1, 1'b1, 21, 4);
    for (int k = 0; k < 4; k++) begin
      wait_done(own, lat);
      chk_res($sformatf("alt%0d", k), own, k % 2,
              (k % 2) ? 5 : 6, (k % 2) ? 1 : 2, 0);
    end
    drive(0, 1'b0, 20, 3);
    drive(1, 1'b0, 21, 4);
    @(negedge clk);

    // Reset while waiting for the divider: no done, all outputs cleared.
    busy_cfg = 12;
    drive(0, 1'b1, 200, 3);
    wait_start(ok);
    chk("abort_start_seen", ok, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    rst = 1'b0;
    drive(0, 1'b0, 200, 3);
    busy_cfg = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_nodone", int'(done0 | done1), 0);
    end
    drive(0, 1'b1, 81, 9);
    wait_done(own, lat);
    chk_res("after_abort", own, 0, 9, 0, 0);
    drive(0, 1'b0, 81, 9);
    @(negedge clk);

    // Operands changed right after grant must not affect the result.
    drive(0, 1'b1, 100, 7);
    @(negedge clk);
    drive(0, 1'b1, 3, 0);
    wait_done(own, lat);
    chk_res("latch", own, 0, 14, 2, 0);
    drive(0, 1'b0, 3, 0);
    @(negedge clk);

    // Random traffic against a request-level model.
    begin
      int pend[2], pa[2], pb[2], rcyc[2];
      int last_owner, last_done, cyc, nz_ops, hq, hr, hdz, jd, eq, er, edz, unfair;
      do_reset();
      pend = '{0, 0}; pa = '{0, 0}; pb = '{0, 0}; rcyc = '{0, 0};
      cyc = 0; last_owner = 1; last_done = 0; nz_ops = 0;
      hq = 0; hr = 0; hdz = 0;
      s0 = nstart;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        cyc++;
        jd = -1;
        if (done0 || done1) begin
          own = done1 ? 1 : 0;
          chk("rnd_excl", int'(done0 & done1), 0);
          chk("rnd_pending", pend[own], 1);
          if (pb[own] == 0) begin eq = 511; er = pa[own]; edz = 1; end
          else begin eq = pa[own] / pb[own]; er = pa[own] % pb[own]; edz = 0; end
          chk_res("rnd", own, own, eq, er, edz);
          unfair = (pend[1-own] != 0 && rcyc[1-own] <= last_done && own == last_owner) ? 1 : 0;
          chk("rnd_fair", unfair, 0);
          last_owner = own; last_done = cyc;
          hq = eq; hr = er; hdz = edz;
          pend[own] = 0; jd = own;
          drive(own, 1'b0, pa[own], pb[own]);
        end else begin
          chk("rnd_hold_q", int'(q_out), hq);
          chk("rnd_hold_r", int'(r_out), hr);
          chk("rnd_hold_dz", int'(dz_err), hdz);
        end
        for (int i = 0; i < 2; i++) begin
          if (pend[i] == 0 && i != jd && t < 2500 && $urandom_range(0, 3) == 0) begin
            pa[i] = int'($urandom_range(0, 511));
            pb[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 511));
            if (pb[i] != 0) nz_ops++;
            pend[i] = 1; rcyc[i] = cyc;
            drive(i, 1'b1, pa[i], pb[i]);
          end
        end
        if (t >= 2500 && pend[0] == 0 && pend[1] == 0) break;
      end
      chk("rnd_drain", pend[0] + pend[1], 0);
      chk("rnd_starts", nstart - s0, nz_ops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
